// File: rtl/up_pkg.sv
// Shared opcodes, controller state encoding and accumulator-select codes for
// the accumulator microprocessor control unit.
package up_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_RES = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Debug codes reported on State; every execute state collapses to DBG_EXEC
  localparam logic [2:0] DBG_FETCH  = 3'd0;
  localparam logic [2:0] DBG_DECODE = 3'd1;
  localparam logic [2:0] DBG_EXEC   = 3'd2;
  localparam logic [2:0] DBG_INWAIT = 3'd3;
  localparam logic [2:0] DBG_HALT   = 3'd7;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EX_LOAD,
    S_EX_STORE,
    S_EX_ADD,
    S_EX_SUB,
    S_EX_IN,
    S_EX_JZ,
    S_EX_JPOS,
    S_HALT
  } state_t;

endpackage

// File: rtl/up_enter_sync.sv
// Synchronises the asynchronous Enter key and produces a one-cycle pulse on
// each synchronised rising edge.
module up_enter_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_async,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/up_control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath; drives
// every datapath control line and waits on the Enter key for IN.
module up_control_unit
  import up_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            Enter,
  input  logic [OP_W-1:0] IR,
  input  logic            Aeq0,
  input  logic            Apos,
  output logic            IRload,
  output logic            JMPmux,
  output logic            PCload,
  output logic            Meminst,
  output logic            MemWr,
  output logic            Aload,
  output logic            Sub,
  output logic [1:0]      Asel,
  output logic            Halt,
  output logic [2:0]      State
);

  state_t     r_state;
  state_t     w_nextState;
  logic       w_enterPulse;
  logic       w_irLoad;
  logic       w_jmpMux;
  logic       w_pcLoad;
  logic       w_memInst;
  logic       w_memWr;
  logic       w_aLoad;
  logic       w_sub;
  logic [1:0] w_aSel;
  logic       w_halt;
  logic [2:0] w_stateDbg;

  up_enter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_enterSync (
    .i_clk  (CLOCK),
    .i_rstN (RESET),
    .i_async(Enter),
    .o_pulse(w_enterPulse)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_irLoad    = 1'b0;
    w_jmpMux    = 1'b0;
    w_pcLoad    = 1'b0;
    w_memInst   = 1'b0;
    w_memWr     = 1'b0;
    w_aLoad     = 1'b0;
    w_sub       = 1'b0;
    w_aSel      = ASEL_RES;
    w_halt      = 1'b0;
    w_stateDbg  = DBG_EXEC;
    case (r_state)
      S_FETCH: begin
        w_irLoad    = 1'b1;
        w_pcLoad    = 1'b1;
        w_stateDbg  = DBG_FETCH;
        w_nextState = S_DECODE;
      end
      S_DECODE: begin
        w_memInst  = 1'b1;
        w_stateDbg = DBG_DECODE;
        case (IR)
          OP_LOAD:  w_nextState = S_EX_LOAD;
          OP_STORE: w_nextState = S_EX_STORE;
          OP_ADD:   w_nextState = S_EX_ADD;
          OP_SUB:   w_nextState = S_EX_SUB;
          OP_IN:    w_nextState = S_EX_IN;
          OP_JZ:    w_nextState = S_EX_JZ;
          OP_JPOS:  w_nextState = S_EX_JPOS;
          default:  w_nextState = S_HALT;
        endcase
      end
      S_EX_LOAD: begin
        w_memInst   = 1'b1;
        w_aSel      = ASEL_MEM;
        w_aLoad     = 1'b1;
        w_nextState = S_FETCH;
      end
      S_EX_STORE: begin
        w_memInst   = 1'b1;
        w_memWr     = 1'b1;
        w_nextState = S_FETCH;
      end
      S_EX_ADD, S_EX_SUB: begin
        w_memInst   = 1'b1;
        w_aLoad     = 1'b1;
        w_sub       = (r_state == S_EX_SUB);
        w_nextState = S_FETCH;
      end
      S_EX_IN: begin
        // Only an edge seen while already waiting here loads A
        if (w_enterPulse) begin
          w_aSel      = ASEL_IN;
          w_aLoad     = 1'b1;
          w_nextState = S_FETCH;
        end else begin
          w_stateDbg = DBG_INWAIT;
        end
      end
      S_EX_JZ, S_EX_JPOS: begin
        if ((r_state == S_EX_JZ) ? Aeq0 : Apos) begin
          w_jmpMux = 1'b1;
          w_pcLoad = 1'b1;
        end
        w_nextState = S_FETCH;
      end
      S_HALT: begin
        w_halt     = 1'b1;
        w_stateDbg = DBG_HALT;
      end
      default: begin
        w_nextState = S_FETCH;
      end
    endcase
  end

  // Holding reset low silences every control line so an interrupted STORE never writes
  assign IRload  = RESET & w_irLoad;
  assign JMPmux  = RESET & w_jmpMux;
  assign PCload  = RESET & w_pcLoad;
  assign Meminst = RESET & w_memInst;
  assign MemWr   = RESET & w_memWr;
  assign Aload   = RESET & w_aLoad;
  assign Sub     = RESET & w_sub;
  assign Asel    = RESET ? w_aSel : ASEL_RES;
  assign Halt    = RESET & w_halt;
  assign State   = w_stateDbg;

endmodule

// File: tb/tb_up_control_unit.sv
// Self-checking bench for up_control_unit: an instruction-level model of the
// whole accumulator machine (RAM, A, PC, IR) predicts every control output.
module tb_up_control_unit;

  localparam int SYNC = 2;

  logic       CLOCK;
  logic       RESET;
  logic       Enter;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [2:0] State;

  up_control_unit #(
    .OP_W(3),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .Enter  (Enter),
    .IR     (IR),
    .Aeq0   (Aeq0),
    .Apos   (Apos),
    .IRload (IRload),
    .JMPmux (JMPmux),
    .PCload (PCload),
    .Meminst(Meminst),
    .MemWr  (MemWr),
    .Aload  (Aload),
    .Sub    (Sub),
    .Asel   (Asel),
    .Halt   (Halt),
    .State  (State)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checkCount = 0;
  int passCount  = 0;
  logic checkEn = 1'b0;

  // Program image loaded into the model RAM whenever reset is held
  logic [7:0] progImg [32];
  logic [7:0] inputVal;

  // Model of the machine: phase 0 fetch, 1 decode, 2 execute, 3 halted
  logic [7:0]    mRam [32];
  logic [7:0]    mA;
  logic [7:0]    mIR;
  logic [4:0]    mPC;
  int            mPhase = 0;
  logic [SYNC:0] mHist;
  logic          mPulse;
  logic [2:0]    mOp;
  logic [4:0]    mAddr;

  logic       eIRload, eJMPmux, ePCload, eMeminst, eMemWr, eAload, eSub, eHalt;
  logic [1:0] eAsel;
  logic [2:0] eState;

  assign mOp    = mIR[7:5];
  assign IR     = mOp;
  assign Aeq0   = (mA == 8'd0);
  assign Apos   = ~mA[7];
  // A key press is recognised once Enter has been seen high SYNC edges ago but low just before
  assign mPulse = mHist[SYNC-1] & ~mHist[SYNC];

  // Expected controls derived from the instruction rules for the current phase
  always_comb begin
    eIRload  = 1'b0;
    eJMPmux  = 1'b0;
    ePCload  = 1'b0;
    eMeminst = 1'b0;
    eMemWr   = 1'b0;
    eAload   = 1'b0;
    eSub     = 1'b0;
    eAsel    = 2'b00;
    eHalt    = 1'b0;
    eState   = 3'd2;
    if (mPhase == 0) begin
      eIRload = 1'b1;
      ePCload = 1'b1;
      eState  = 3'd0;
    end else if (mPhase == 1) begin
      eMeminst = 1'b1;
      eState   = 3'd1;
    end else if (mPhase == 3) begin
      eHalt  = 1'b1;
      eState = 3'd7;
    end else begin
      case (mOp)
        3'd0: begin eMeminst = 1'b1; eAload = 1'b1; eAsel = 2'b10; end
        3'd1: begin eMeminst = 1'b1; eMemWr = 1'b1; end
        3'd2: begin eMeminst = 1'b1; eAload = 1'b1; end
        3'd3: begin eMeminst = 1'b1; eAload = 1'b1; eSub = 1'b1; end
        3'd4: begin
          if (mPulse) begin eAload = 1'b1; eAsel = 2'b01; end
          else eState = 3'd3;
        end
        3'd5: begin ePCload = Aeq0; eJMPmux = Aeq0; end
        3'd6: begin ePCload = Apos; eJMPmux = Apos; end
        default: ;
      endcase
    end
    if (!RESET) begin
      {eIRload, eJMPmux, ePCload, eMeminst, eMemWr, eAload, eSub, eHalt} = '0;
      eAsel = 2'b00;
    end
  end

  // Model datapath and instruction progress, advanced from the expected controls
  always @(posedge CLOCK) begin
    if (!RESET) begin
      mPhase <= 0;
      mHist  <= '0;
      mA     <= 8'd0;
      mPC    <= 5'd0;
      mIR    <= 8'd0;
      for (int i = 0; i < 32; i++) mRam[i] <= progImg[i];
    end else begin
      mHist <= {mHist[SYNC-1:0], Enter};
      mAddr =  eMeminst ? mIR[4:0] : mPC;
      if (eIRload) mIR <= mRam[mAddr];
      if (ePCload) mPC <= eJMPmux ? mIR[4:0] : mPC + 5'd1;
      if (eMemWr) mRam[mAddr] <= mA;
      if (eAload) begin
        if (eAsel == 2'b01)      mA <= inputVal;
        else if (eAsel[1])       mA <= mRam[mAddr];
        else if (eSub)           mA <= mA - mRam[mAddr];
        else                     mA <= mA + mRam[mAddr];
      end
      if (mPhase == 0)      mPhase <= 1;
      else if (mPhase == 1) mPhase <= (mOp == 3'd7) ? 3 : 2;
      else if (mPhase == 2) begin
        if (!(mOp == 3'd4 && !mPulse)) mPhase <= 0;
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge CLOCK) begin
    if (checkEn) begin
      checkVal("controls", 32'({IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt}),
               32'({eIRload, eJMPmux, ePCload, eMeminst, eMemWr, eAload, eSub, eAsel, eHalt}));
      if (RESET) checkVal("state", 32'(State), 32'(eState));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkVal(name, act, exp);
  endtask

  // Holds reset for two edges, checks the reset state, then releases in the first fetch cycle
  task automatic applyStimulus();
    RESET = 1'b0;
    step(2);
    checkOutput("reset IRload", 32'(IRload), 32'd0);
    checkOutput("reset Halt", 32'(Halt), 32'd0);
    checkOutput("reset State", 32'(State), 32'd0);
    RESET = 1'b1;
  endtask

  task automatic clearProg();
    for (int i = 0; i < 32; i++) progImg[i] = 8'hE0;
  endtask

  int pulses;
  int pulseAt;
  int haltOk;

  initial begin
    RESET    = 1'b0;
    Enter    = 1'b0;
    inputVal = 8'h00;
    clearProg();
    step(2);
    checkEn = 1'b1;

    $display("[TB] program LOAD 30; ADD 31; STORE 29; HALT");
    clearProg();
    progImg[0] = 8'h1E; progImg[1] = 8'h5F; progImg[2] = 8'h3D; progImg[3] = 8'hE0;
    progImg[30] = 8'd5; progImg[31] = 8'd7;
    applyStimulus();
    @(negedge CLOCK);
    checkOutput("first fetch IRload", 32'(IRload), 32'd1);
    step(11);
    @(negedge CLOCK);
    checkOutput("p1 Halt", 32'(Halt), 32'd1);
    checkOutput("p1 State", 32'(State), 32'd7);
    checkOutput("p1 M29", 32'(mRam[29]), 32'd12);
    checkOutput("p1 PC", 32'(mPC), 32'd4);

    $display("[TB] reset during STORE");
    applyStimulus();
    step(8);
    @(negedge CLOCK);
    checkOutput("store MemWr", 32'(MemWr), 32'd1);
    #1 RESET = 1'b0;
    #1 checkOutput("store gated MemWr", 32'(MemWr), 32'd0);
    step(2);
    RESET = 1'b1;
    @(negedge CLOCK);
    checkOutput("post-reset IRload", 32'(IRload), 32'd1);
    checkOutput("post-reset State", 32'(State), 32'd0);
    step(14);

    $display("[TB] SUB to zero then JZ");
    clearProg();
    progImg[0] = 8'h14; progImg[1] = 8'h75; progImg[2] = 8'hAA;
    progImg[10] = 8'h16; progImg[11] = 8'hA0; progImg[12] = 8'hE0;
    progImg[20] = 8'd3; progImg[21] = 8'd3; progImg[22] = 8'd1;
    applyStimulus();
    step(8);
    @(negedge CLOCK);
    checkOutput("jz taken", 32'({JMPmux, PCload}), 32'd3);
    step(6);
    @(negedge CLOCK);
    checkOutput("jz not taken", 32'({JMPmux, PCload}), 32'd0);
    step(10);
    @(negedge CLOCK);
    checkOutput("jz PC", 32'(mPC), 32'd13);
    checkOutput("jz Halt", 32'(Halt), 32'd1);

    $display("[TB] JPOS with negative then zero A");
    clearProg();
    progImg[0] = 8'h14; progImg[1] = 8'hC5; progImg[2] = 8'h15; progImg[3] = 8'hC8;
    progImg[20] = 8'h80; progImg[21] = 8'h00;
    applyStimulus();
    step(5);
    @(negedge CLOCK);
    checkOutput("jpos neg", 32'({JMPmux, PCload}), 32'd0);
    step(6);
    @(negedge CLOCK);
    checkOutput("jpos zero", 32'({JMPmux, PCload}), 32'd3);
    step(12);
    @(negedge CLOCK);
    checkOutput("jpos PC", 32'(mPC), 32'd9);

    $display("[TB] IN with delayed Enter");
    clearProg();
    progImg[0] = 8'h80; progImg[1] = 8'h3D;
    inputVal = 8'hA7;
    applyStimulus();
    step(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      checkOutput("in wait", 32'({State, Aload}), 32'({3'd3, 1'b0}));
    end
    step(1);
    Enter   = 1'b1;
    pulses  = 0;
    pulseAt = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      if (Aload) begin
        pulses++;
        pulseAt = i;
      end
    end
    checkOutput("in pulse count", 32'(pulses), 32'd1);
    checkOutput("in pulse delay", 32'(pulseAt), 32'(SYNC));
    step(1);
    Enter = 1'b0;
    step(4);
    @(negedge CLOCK);
    checkOutput("in M29", 32'(mRam[29]), 32'hA7);

    $display("[TB] HALT with Enter toggling");
    haltOk = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      Enter = 1'($urandom_range(0, 1));
      @(negedge CLOCK);
      if (State == 3'd7 && Halt &&
          {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel} == 9'd0) haltOk++;
    end
    checkOutput("halt cycles", 32'(haltOk), 32'd100);

    $display("[TB] random programs");
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < 32; i++) begin
        progImg[i] = 8'($urandom);
        if (progImg[i][7:5] == 3'd7 && $urandom_range(0, 3) != 0)
          progImg[i][7:5] = 3'($urandom_range(0, 6));
      end
      inputVal = 8'($urandom);
      Enter    = 1'b0;
      applyStimulus();
      for (int c = 0; c < 300; c++) begin
        step(1);
        RESET = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 5) == 0) Enter = ~Enter;
      end
      RESET = 1'b1;
    end

    step(2);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
